// File: rtl/reg_write_port_arbiter.sv
// Register file write-port arbiter.
// The in-order commit stream always wins the port. Late writebacks wait in a
// small FIFO and drain in cycles where commit is idle. A commit to register X
// kills every queued late result for X, because the commit is always younger.
// A starve counter raises stallReq so that a live late result cannot wait
// forever behind a busy commit stream.
module reg_write_port_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8,
    parameter int ADDR_WIDTH   = 5,
    parameter int XLEN         = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       commitEnable,
    input  logic [ADDR_WIDTH-1:0]      commitAddr,
    input  logic [XLEN-1:0]            commitValue,
    input  logic                       lateValid,
    output logic                       lateReady,
    input  logic [ADDR_WIDTH-1:0]      lateAddr,
    input  logic [XLEN-1:0]            lateValue,
    output logic                       stallReq,
    output logic [(1<<ADDR_WIDTH)-1:0] pendingMask,
    output logic                       writeEnable,
    output logic [ADDR_WIDTH-1:0]      writeAddr,
    output logic [XLEN-1:0]            writeValue
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);
    localparam int NREG  = 1 << ADDR_WIDTH;

    // FIFO storage: one live bit, destination and data per entry
    logic                  live_q  [DEPTH];
    logic                  live_d  [DEPTH];
    logic [ADDR_WIDTH-1:0] addr_q  [DEPTH];
    logic [ADDR_WIDTH-1:0] addr_d  [DEPTH];
    logic [XLEN-1:0]       value_q [DEPTH];
    logic [XLEN-1:0]       value_d [DEPTH];

    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [STV_W-1:0]      starve_q, starve_d;
    logic                  stall_q, stall_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [XLEN-1:0]       wvalue_q, wvalue_d;

    logic commit_eff;
    logic fifo_empty;
    logic fifo_full;
    logic push_store;
    logic pop;
    logic head_live;

    // Port arbitration, FIFO bookkeeping, WAW kill and starvation tracking
    always_comb begin
        commit_eff = commitEnable && (commitAddr != '0);
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == CNT_W'(DEPTH));
        // A handshake to r0 completes but leaves nothing behind
        push_store = lateValid && !fifo_full && (lateAddr != '0);
        pop        = !commit_eff && !fifo_empty;
        head_live  = live_q[rd_ptr_q];

        we_d     = 1'b0;
        waddr_d  = '0;
        wvalue_d = '0;
        if (commit_eff) begin
            we_d     = 1'b1;
            waddr_d  = commitAddr;
            wvalue_d = commitValue;
        end else if (pop && head_live) begin
            we_d     = 1'b1;
            waddr_d  = addr_q[rd_ptr_q];
            wvalue_d = value_q[rd_ptr_q];
        end

        for (int i = 0; i < DEPTH; i++) begin
            live_d[i]  = live_q[i];
            addr_d[i]  = addr_q[i];
            value_d[i] = value_q[i];
            if (commit_eff && (addr_q[i] == commitAddr)) begin
                live_d[i] = 1'b0;
            end
            // Popped slots are killed so the pending mask only sees occupied entries
            if (pop && (rd_ptr_q == PTR_W'(i))) begin
                live_d[i] = 1'b0;
            end
            // A late result racing a same-register commit is older: store it dead
            if (push_store && (wr_ptr_q == PTR_W'(i))) begin
                live_d[i]  = !(commit_eff && (lateAddr == commitAddr));
                addr_d[i]  = lateAddr;
                value_d[i] = lateValue;
            end
        end

        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        wr_ptr_d = push_store ? wr_ptr_q + 1'b1 : wr_ptr_q;
        count_d  = count_q + CNT_W'(push_store) - CNT_W'(pop);

        starve_d = starve_q;
        if (fifo_empty || pop) begin
            starve_d = '0;
        end else if (head_live && (starve_q != STV_W'(STARVE_LIMIT))) begin
            starve_d = starve_q + 1'b1;
        end
        stall_d = (starve_d == STV_W'(STARVE_LIMIT));
    end

    // State register; entry payloads need no reset since live gates them
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                live_q[i] <= 1'b0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
            stall_q  <= 1'b0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wvalue_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                live_q[i] <= live_d[i];
            end
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            stall_q  <= stall_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wvalue_q <= wvalue_d;
        end
        for (int i = 0; i < DEPTH; i++) begin
            addr_q[i]  <= addr_d[i];
            value_q[i] <= value_d[i];
        end
    end

    // Pending mask: register r is pending while any live entry targets it
    genvar gi, gj;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_pend
            if (gi == 0) begin : g_zero
                assign pendingMask[gi] = 1'b0;
            end else begin : g_reg
                logic [DEPTH-1:0] hit;
                for (gj = 0; gj < DEPTH; gj++) begin : g_hit
                    assign hit[gj] = live_q[gj] && (addr_q[gj] == ADDR_WIDTH'(gi));
                end
                assign pendingMask[gi] = |hit;
            end
        end
    endgenerate

    assign lateReady   = !fifo_full;
    assign stallReq    = stall_q;
    assign writeEnable = we_q;
    assign writeAddr   = waddr_q;
    assign writeValue  = wvalue_q;

endmodule

// File: tb/tb_reg_write_port_arbiter.sv
// Bench for reg_write_port_arbiter: directed scenarios plus randomized traffic,
// all checked every cycle against a queue-based reference model.
module tb_reg_write_port_arbiter;

    localparam int DEPTH = 4;
    localparam int LIMIT = 8;
    localparam int AW    = 5;
    localparam int XLEN  = 32;
    localparam int NREG  = 1 << AW;

    logic            clk = 1'b0;
    logic            rst;
    logic            commitEnable;
    logic [AW-1:0]   commitAddr;
    logic [XLEN-1:0] commitValue;
    logic            lateValid;
    logic            lateReady;
    logic [AW-1:0]   lateAddr;
    logic [XLEN-1:0] lateValue;
    logic            stallReq;
    logic [NREG-1:0] pendingMask;
    logic            writeEnable;
    logic [AW-1:0]   writeAddr;
    logic [XLEN-1:0] writeValue;

    always #5 clk = ~clk;

    reg_write_port_arbiter #(
        .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT), .ADDR_WIDTH(AW), .XLEN(XLEN)
    ) dut (
        .clk(clk), .rst(rst),
        .commitEnable(commitEnable), .commitAddr(commitAddr), .commitValue(commitValue),
        .lateValid(lateValid), .lateReady(lateReady), .lateAddr(lateAddr), .lateValue(lateValue),
        .stallReq(stallReq), .pendingMask(pendingMask),
        .writeEnable(writeEnable), .writeAddr(writeAddr), .writeValue(writeValue)
    );

    typedef struct {
        bit            live;
        bit [AW-1:0]   addr;
        bit [XLEN-1:0] value;
    } ent_t;

    // Reference model state
    ent_t            mq[$];
    int              m_starve = 0;
    bit              m_we = 0;
    bit [AW-1:0]     m_waddr = '0;
    bit [XLEN-1:0]   m_wval = '0;
    bit              m_stall = 0;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [NREG-1:0] model_mask();
        logic [NREG-1:0] m = '0;
        foreach (mq[i]) if (mq[i].live) m[mq[i].addr] = 1'b1;
        m[0] = 1'b0;
        return m;
    endfunction

    // Advance the model by one clock using the inputs currently driven
    task automatic model_step();
        bit ceff, acc, pop, hl;
        int n;
        if (rst) begin
            mq.delete();
            m_starve = 0; m_we = 0; m_waddr = '0; m_wval = '0; m_stall = 0;
            return;
        end
        ceff = commitEnable && (commitAddr != 0);
        n    = mq.size();
        acc  = lateValid && (n < DEPTH);
        pop  = !ceff && (n > 0);
        hl   = (n > 0) && mq[0].live;
        m_we = 0; m_waddr = '0; m_wval = '0;
        if (ceff) begin
            m_we = 1; m_waddr = commitAddr; m_wval = commitValue;
        end else if (pop && mq[0].live) begin
            m_we = 1; m_waddr = mq[0].addr; m_wval = mq[0].value;
        end
        if (n == 0 || pop) m_starve = 0;
        else if (hl && m_starve < LIMIT) m_starve++;
        m_stall = (m_starve == LIMIT);
        if (ceff) foreach (mq[i]) if (mq[i].addr == commitAddr) mq[i].live = 0;
        if (pop) void'(mq.pop_front());
        if (acc && lateAddr != 0) begin
            ent_t e;
            e.live  = !(ceff && lateAddr == commitAddr);
            e.addr  = lateAddr;
            e.value = lateValue;
            mq.push_back(e);
        end
    endtask

    task automatic compare_all();
        chk("writeEnable", writeEnable, m_we);
        if (m_we) begin
            chk("writeAddr", writeAddr, m_waddr);
            chk("writeValue", writeValue, m_wval);
        end
        chk("stallReq", stallReq, m_stall);
        chk("lateReady", lateReady, mq.size() != DEPTH);
        chk("pendingMask", pendingMask, model_mask());
        if (writeEnable)
            $display("write r%0d <= %08h (queued=%0d stall=%0b)", writeAddr, writeValue, mq.size(), stallReq);
    endtask

    // One clock: update model, let the DUT clock, then compare on the falling edge
    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic set_commit(input bit en, input logic [AW-1:0] a, input logic [XLEN-1:0] v);
        commitEnable = en; commitAddr = a; commitValue = v;
    endtask

    task automatic set_late(input bit en, input logic [AW-1:0] a, input logic [XLEN-1:0] v);
        lateValid = en; lateAddr = a; lateValue = v;
    endtask

    // Protocol monitor: commit must be held low while stallReq is up
    always @(posedge clk) begin
        if (!rst && stallReq && commitEnable) begin
            errors++;
            $display("FAIL protocol: commitEnable=1 while stallReq=1");
        end
    end

    initial begin
        int n;
        rst = 1'b1;
        set_commit(0, '0, '0);
        set_late(0, '0, '0);
        @(negedge clk);
        tick();
        tick();
        chk("reset_we", writeEnable, 0);
        chk("reset_waddr", writeAddr, 0);
        chk("reset_wval", writeValue, 0);
        chk("reset_ready", lateReady, 1);
        chk("reset_mask", pendingMask, 0);
        chk("reset_stall", stallReq, 0);
        rst = 1'b0;

        // Plain commit, then idle, then a commit to r0 that must not write
        set_commit(1, 5, 32'hDEADBEEF); tick();
        chk("commit_we", writeEnable, 1);
        chk("commit_addr", writeAddr, 5);
        chk("commit_val", writeValue, 32'hDEADBEEF);
        set_commit(0, 0, 0); tick();
        chk("commit_one_cycle", writeEnable, 0);
        set_commit(1, 0, 32'h1234); tick();
        chk("r0_commit_we", writeEnable, 0);

        // Late path through an idle port
        set_commit(0, 0, 0);
        set_late(1, 7, 32'h11);
        chk("late_ready", lateReady, 1);
        tick();
        chk("mask7_set", pendingMask[7], 1);
        set_late(0, 0, 0); tick();
        chk("late_we", writeEnable, 1);
        chk("late_addr", writeAddr, 7);
        chk("late_val", writeValue, 32'h11);
        chk("mask7_clear", pendingMask[7], 0);

        // Fill the FIFO behind a busy commit stream
        for (int i = 0; i < 4; i++) begin
            set_commit(1, 1, $urandom);
            set_late(1, AW'(10 + i), 32'h100 + i);
            tick();
        end
        chk("full_ready", lateReady, 0);
        chk("full_mask", pendingMask, 32'h0000_3C00);
        set_commit(0, 0, 0); set_late(1, 14, 32'h114); tick();
        chk("full_pop_addr", writeAddr, 10);
        chk("full_ready_after_pop", lateReady, 1);
        set_commit(1, 1, $urandom); tick();
        chk("refill_ready", lateReady, 0);
        chk("refill_mask", pendingMask, 32'h0000_7800);
        set_commit(0, 0, 0); set_late(0, 0, 0);
        repeat (5) tick();
        chk("drain_mask", pendingMask, 0);

        // WAW: commit to r9 kills the queued late r9 result
        set_late(1, 9, 32'hAA); tick();
        set_late(0, 0, 0); set_commit(1, 9, 32'hBB); tick();
        chk("waw_addr", writeAddr, 9);
        chk("waw_val", writeValue, 32'hBB);
        chk("waw_mask9", pendingMask[9], 0);
        set_commit(0, 0, 0); tick();
        chk("waw_silent_pop", writeEnable, 0);

        // Starvation: one live entry behind a continuous commit stream
        set_late(1, 3, 32'h33); tick();
        set_late(0, 0, 0); set_commit(1, 4, 32'h44);
        n = 0;
        while (n < 20 && !stallReq) begin
            tick();
            n++;
        end
        chk("starve_cycles", n, 8);
        set_commit(0, 0, 0); tick();
        chk("starve_write_addr", writeAddr, 3);
        chk("starve_write_val", writeValue, 32'h33);
        chk("starve_stall_clear", stallReq, 0);

        // Reset with three entries queued
        for (int i = 0; i < 3; i++) begin
            set_commit(1, 2, $urandom);
            set_late(1, AW'(20 + i), $urandom);
            tick();
        end
        chk("preq_mask", pendingMask, 32'h0070_0000);
        rst = 1'b1; set_commit(0, 0, 0); set_late(0, 0, 0); tick();
        chk("rst_mid_we", writeEnable, 0);
        chk("rst_mid_ready", lateReady, 1);
        chk("rst_mid_mask", pendingMask, 0);
        rst = 1'b0;
        repeat (4) begin
            tick();
            chk("post_rst_no_write", writeEnable, 0);
        end

        // Randomized traffic on a small register range to force collisions
        for (int c = 0; c < 1500; c++) begin
            rst          = ($urandom_range(0, 199) == 0);
            commitEnable = !m_stall && ($urandom_range(0, 2) != 0);
            commitAddr   = AW'($urandom_range(0, 7));
            commitValue  = $urandom;
            lateValid    = $urandom_range(0, 1) != 0;
            lateAddr     = AW'($urandom_range(0, 7));
            lateValue    = $urandom;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
